grayscale_convert: RTL and testbench

Per-pixel RGB-to-luma conversion stage of the grayscale accelerator. It consumes the 512-bit read-response cachelines that the requestor emits on `data_out`/`valid_out`, converts all 16 BGRA pixels in each line to grayscale, and returns the result on the requestor's `data_in`/`valid_in` path, which enqueues it into the write FIFO. The block is a fixed-latency, fully pipelined datapath with no backpressure; it also exports line and drop counters for debug and DSM reporting.

---
 rtl/grayscale_convert.sv | 145 ++++++++++++++
 tb/tb_grayscale_convert.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/grayscale_convert.sv
// BGRA-to-luma conversion of 16 pixels per 512-bit line, output {A,Y,Y,Y}.
// Fixed 3-cycle latency, one line per cycle, no backpressure; with line/drop debug counters.
module grayscale_convert #(
  parameter int unsigned R_COEF           = 77,
  parameter int unsigned G_COEF           = 150,
  parameter int unsigned B_COEF           = 29,
  parameter logic [31:0] HC_CONTROL_START = 32'h0000_0001
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  hc_control,
  input  logic [511:0] line_in,
  input  logic         line_in_valid,
  output logic [511:0] line_out,
  output logic         line_out_valid,
  output logic [31:0]  lines_done,
  output logic [31:0]  lines_dropped,
  output logic         busy
);

  if (R_COEF + G_COEF + B_COEF != 256) begin : g_coef_check
    $error("grayscale_convert: R_COEF + G_COEF + B_COEF must equal 256");
  end

  localparam logic [15:0] RC = 16'(R_COEF);
  localparam logic [15:0] GC = 16'(G_COEF);
  localparam logic [15:0] BC = 16'(B_COEF);

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] pr;
    logic [15:0] pg;
    logic [15:0] pb;
  } prod_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] y;
  } luma_t;

  logic [1:0]        rst_sync;
  logic              rst_n;
  logic              is_start;
  logic              start_prev;
  logic              accept;
  logic              drop;
  logic              clear;
  prod_t [15:0]      s1_nxt;
  prod_t [15:0]      s1_dat;
  logic              s1_vld;
  luma_t [15:0]      s2_nxt;
  luma_t [15:0]      s2_dat;
  logic              s2_vld;
  logic [511:0]      s3_nxt;

  // Assertion is immediate; release takes effect two edges later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign is_start = (hc_control == HC_CONTROL_START);
  assign accept   = line_in_valid && is_start;
  assign drop     = line_in_valid && !is_start;
  assign clear    = is_start && !start_prev;

  always_comb begin
    pixel_t px;
    px     = '0;
    s1_nxt = '0;
    for (int p = 0; p < 16; p++) begin
      px            = line_in[32*p +: 32];
      s1_nxt[p].a   = px.a;
      s1_nxt[p].pr  = RC * {8'h00, px.r};
      s1_nxt[p].pg  = GC * {8'h00, px.g};
      s1_nxt[p].pb  = BC * {8'h00, px.b};
    end
  end

  // Weights sum to 256, so the rounded sum never reaches bit 16.
  always_comb begin
    logic [16:0] sum;
    sum    = '0;
    s2_nxt = '0;
    for (int p = 0; p < 16; p++) begin
      sum          = {1'b0, s1_dat[p].pr} + {1'b0, s1_dat[p].pg} + {1'b0, s1_dat[p].pb} + 17'd128;
      s2_nxt[p].y  = 8'(sum >> 8);
      s2_nxt[p].a  = s1_dat[p].a;
    end
  end

  always_comb begin
    s3_nxt = '0;
    for (int p = 0; p < 16; p++) begin
      s3_nxt[32*p +: 32] = {s2_dat[p].a, s2_dat[p].y, s2_dat[p].y, s2_dat[p].y};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld         <= 1'b0;
      s1_dat         <= '0;
      s2_vld         <= 1'b0;
      s2_dat         <= '0;
      line_out_valid <= 1'b0;
      line_out       <= '0;
    end else begin
      s1_vld         <= accept;
      s2_vld         <= s1_vld;
      line_out_valid <= s2_vld;
      if (accept) s1_dat   <= s1_nxt;
      if (s1_vld) s2_dat   <= s2_nxt;
      if (s2_vld) line_out <= s3_nxt;
    end
  end

  // A start rising edge clears both counters and overrides any increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_prev    <= 1'b0;
      lines_done    <= '0;
      lines_dropped <= '0;
    end else begin
      start_prev <= is_start;
      if (clear) begin
        lines_done    <= '0;
        lines_dropped <= '0;
      end else begin
        if (line_out_valid) lines_done    <= lines_done + 32'd1;
        if (drop)           lines_dropped <= lines_dropped + 32'd1;
      end
    end
  end

  assign busy = s1_vld || s2_vld || line_out_valid;

endmodule

// File: tb/tb_grayscale_convert.sv
// Randomised bench for grayscale_convert against a per-line arithmetic reference with a timestamped queue.
module tb_grayscale_convert;

  localparam logic [31:0] START = 32'h0000_0001;
  localparam int RW = 77;
  localparam int GW = 150;
  localparam int BW = 29;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  hc_control;
  logic [511:0] line_in;
  logic         line_in_valid;
  logic [511:0] line_out;
  logic         line_out_valid;
  logic [31:0]  lines_done;
  logic [31:0]  lines_dropped;
  logic         busy;

  always #5 clk = ~clk;

  grayscale_convert #(
    .R_COEF(RW), .G_COEF(GW), .B_COEF(BW), .HC_CONTROL_START(START)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hc_control(hc_control),
    .line_in(line_in),
    .line_in_valid(line_in_valid),
    .line_out(line_out),
    .line_out_valid(line_out_valid),
    .lines_done(lines_done),
    .lines_dropped(lines_dropped),
    .busy(busy)
  );

  typedef struct {
    int           due;
    logic [511:0] dat;
  } exp_t;

  exp_t         q[$];
  int           n_chk = 0;
  int           n_err = 0;
  int           stp = 0;
  logic [31:0]  m_done;
  logic [31:0]  m_drop;
  logic         m_prev;
  logic [511:0] m_last;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] ref_line(input logic [511:0] l);
    logic [511:0] r;
    r = '0;
    for (int p = 0; p < 16; p++) begin
      logic [31:0] px;
      int y;
      px = l[32*p +: 32];
      y  = (RW * px[23:16] + GW * px[15:8] + BW * px[7:0] + 128) / 256;
      r[32*p +: 32] = {px[31:24], y[7:0], y[7:0], y[7:0]};
    end
    return r;
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom();
    return l;
  endfunction

  // One cycle: check outputs against the model, then present the next inputs.
  task automatic step(input logic v, input logic [511:0] l, input logic [31:0] hc);
    logic ev;
    logic st;
    exp_t e;
    @(negedge clk);
    chk("lines_done", lines_done, m_done);
    chk("lines_dropped", lines_dropped, m_drop);
    chk("busy", busy, q.size() > 0);
    ev = (q.size() > 0) && (q[0].due == stp);
    chk("line_out_valid", line_out_valid, ev);
    if (ev) begin
      m_last = q[0].dat;
      q.delete(0);
    end
    chk("line_out", line_out, m_last);
    line_in_valid = v;
    line_in       = l;
    hc_control    = hc;
    st = (hc == START);
    if (st && !m_prev) begin
      m_done = '0;
      m_drop = '0;
    end else begin
      m_done = m_done + 32'(ev);
      m_drop = m_drop + 32'(v && !st);
    end
    m_prev = st;
    if (v && st) begin
      e.due = stp + 3;
      e.dat = ref_line(l);
      q.push_back(e);
    end
    stp++;
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b0;
    #1;
    chk("rst_valid", line_out_valid, 0);
    chk("rst_busy", busy, 0);
    q.delete();
    m_done = '0;
    m_drop = '0;
    m_prev = 1'b0;
    m_last = '0;
    for (int i = 0; i < hold; i++) begin
      line_in       = rand_line();
      line_in_valid = 1'($urandom_range(0, 1));
      hc_control    = ($urandom_range(0, 1) == 1) ? START : $urandom();
      @(negedge clk);
      chk("rst_line_out", line_out, 0);
      chk("rst_line_out_valid", line_out_valid, 0);
      chk("rst_lines_done", lines_done, 0);
      chk("rst_lines_dropped", lines_dropped, 0);
      chk("rst_busy_hold", busy, 0);
    end
    line_in_valid = 1'b0;
    line_in       = '0;
    hc_control    = '0;
    reset         = 1'b1;
    repeat (3) step(1'b0, '0, 32'h0);
  endtask

  logic [31:0] prim_in  [5] = '{32'h80FF0000, 32'h0000FF00, 32'h000000FF, 32'hFFFFFFFF, 32'h00000000};
  logic [31:0] prim_exp [5] = '{32'h804D4D4D, 32'h00959595, 32'h001D1D1D, 32'hFFFFFFFF, 32'h00000000};

  initial begin
    logic [31:0] hc;
    logic [7:0]  k8;
    reset         = 1'b0;
    hc_control    = '0;
    line_in       = '0;
    line_in_valid = 1'b0;
    do_reset(5);

    repeat (3) step(1'b0, '0, START);
    chk("idle_busy", busy, 0);
    chk("idle_done", lines_done, 0);

    for (int i = 0; i < 5; i++) begin
      step(1'b1, {16{prim_in[i]}}, START);
      repeat (4) step(1'b0, '0, START);
      chk("primary", line_out, {16{prim_exp[i]}});
    end

    repeat (60) begin
      case ($urandom_range(0, 9))
        0, 1:    hc = 32'h0;
        2:       hc = 32'h3;
        default: hc = START;
      endcase
      step(($urandom_range(0, 3) != 0), rand_line(), hc);
    end
    repeat (4) step(1'b0, '0, START);

    step(1'b0, '0, 32'h0);
    for (int k = 0; k < 33; k++) begin
      k8 = 8'(k);
      step(1'b1, {16{k8, k8, k8, k8}}, START);
    end
    repeat (4) step(1'b0, '0, START);
    chk("stream_done", lines_done, 33);

    repeat (5) step(1'b1, rand_line(), 32'h0);
    step(1'b0, '0, 32'h0);
    chk("not_started_dropped", lines_dropped, 5);
    chk("not_started_done", lines_done, 33);
    step(1'b0, '0, START);
    step(1'b0, '0, START);
    chk("clear_done", lines_done, 0);
    chk("clear_dropped", lines_dropped, 0);

    step(1'b0, '0, 32'h0);
    step(1'b1, rand_line(), START);
    repeat (4) step(1'b0, '0, 32'h0);
    chk("stop_midflight_done", lines_done, 1);

    step(1'b0, '0, START);
    step(1'b1, rand_line(), START);
    step(1'b1, rand_line(), START);
    step(1'b0, '0, START);
    do_reset(1);
    repeat (4) step(1'b0, '0, START);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", lines_done, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
